// File: rtl/pc_next_gen_pkg.sv
// Shared PC constants, trap FSM state encoding and redirect payload type
// used by the next-PC sequencer, PC register and fetch stage.
package pc_next_gen_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000);
    localparam logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100);
    localparam logic [XLEN-1:0] PC_INC       = XLEN'(4);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } trap_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] target;
    } redirect_t;

    // Instruction addresses must be word aligned.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Buffers a redirect that arrives while stalled and merges it with the live
// redirect into one effective redirect (newest request wins).
module pc_redirect_buf
    import pc_next_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output redirect_t       eff_c,
    output logic            pend_v
);

    logic [XLEN-1:0] pend_q;

    // Capture while stalled; any unstalled cycle consumes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v <= 1'b0;
            pend_q <= '0;
        end else if (stall) begin
            if (redirect_valid) begin
                pend_v <= 1'b1;
                pend_q <= redirect_target;
            end
        end else begin
            pend_v <= 1'b0;
        end
    end

    always_comb begin
        eff_c = '0;
        if (redirect_valid) begin
            eff_c.valid  = 1'b1;
            eff_c.target = redirect_target;
        end else if (pend_v) begin
            eff_c.valid  = 1'b1;
            eff_c.target = pend_q;
        end
    end

endmodule

// File: rtl/pc_next_gen.sv
// Next-PC sequencer: selects increment, hold, redirect or trap vector and
// tracks misaligned-redirect trap status with a two-state FSM.
module pc_next_gen
    import pc_next_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_clear,
    output logic [XLEN-1:0] pc_next,
    output logic            redirect_pending,
    output logic            misalign_trap,
    output logic            double_fault,
    output logic [XLEN-1:0] trap_pc
);

    trap_state_e     state_q;
    trap_state_e     state_d;
    redirect_t       eff;
    logic            misalign_d;
    logic            double_d;
    logic [XLEN-1:0] trap_pc_d;
    logic [XLEN-1:0] pc_mux;
    logic            misaligned;
    logic            trap_take;

    pc_redirect_buf u_redirect_buf (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .eff_c           (eff),
        .pend_v          (redirect_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            misalign_trap <= 1'b0;
            double_fault  <= 1'b0;
            trap_pc       <= '0;
        end else begin
            state_q       <= state_d;
            misalign_trap <= misalign_d;
            double_fault  <= double_d;
            trap_pc       <= trap_pc_d;
        end
    end

    // A trap_clear colliding with a new misaligned redirect re-arms the trap.
    always_comb begin
        state_d    = state_q;
        misalign_d = misalign_trap;
        double_d   = double_fault;
        trap_pc_d  = trap_pc;
        pc_mux     = pc + PC_INC;
        misaligned = eff.valid && !is_aligned(eff.target);
        trap_take  = !stall && misaligned && ((state_q == RUN) || trap_clear);

        if ((state_q == TRAP) && trap_clear) begin
            state_d    = RUN;
            misalign_d = 1'b0;
            double_d   = 1'b0;
        end

        if (stall) begin
            pc_mux = pc;
        end else if (eff.valid) begin
            if (!misaligned) begin
                pc_mux = eff.target;
            end else if (trap_take) begin
                pc_mux     = TRAP_VECTOR;
                state_d    = TRAP;
                misalign_d = 1'b1;
                double_d   = 1'b0;
                trap_pc_d  = eff.target;
            end else begin
                double_d = 1'b1;
            end
        end
    end

    assign pc_next = rst_n ? pc_mux : RESET_VECTOR;

endmodule

// File: tb/tb_pc_next_gen.sv
// Scenario bench for pc_next_gen: expected pc_next values are queued as
// stimulus is applied and compared mid-cycle; status is checked after edges.
module tb_pc_next_gen;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_clear;
    logic [31:0] pc_next;
    logic        redirect_pending;
    logic        misalign_trap;
    logic        double_fault;
    logic [31:0] trap_pc;

    logic        use_fb;
    logic [31:0] pc_drv;
    logic [31:0] pc_reg;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int          n_checks;
    int          n_pass;

    pc_next_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pc               (pc),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .trap_clear       (trap_clear),
        .pc_next          (pc_next),
        .redirect_pending (redirect_pending),
        .misalign_trap    (misalign_trap),
        .double_fault     (double_fault),
        .trap_pc          (trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference PC register closing the loop for sequential runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= 32'h0;
        else        pc_reg <= pc_next;
    end

    assign pc = use_fb ? pc_reg : pc_drv;

    task automatic drive(input logic [31:0] p, input logic s, input logic rv,
                         input logic [31:0] rt, input logic tc);
        pc_drv          = p;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = rt;
        trap_clear      = tc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        use_fb = 1'b1;
        rst_n  = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL reset_pc_next got=%h exp=%h", pc_next, e); else n_pass++;
        n_checks++; if (redirect_pending !== 1'b0) $display("FAIL reset_pending got=%b exp=0", redirect_pending); else n_pass++;
        n_checks++; if (misalign_trap !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign_trap); else n_pass++;
        n_checks++; if (double_fault !== 1'b0) $display("FAIL reset_double got=%b exp=0", double_fault); else n_pass++;
        n_checks++; if (trap_pc !== 32'h0) $display("FAIL reset_trap_pc got=%h exp=0", trap_pc); else n_pass++;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        use_fb = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'(4 * i));
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++; if (pc_next !== e) $display("FAIL seq_%0d got=%h exp=%h", i, pc_next, e); else n_pass++;
            next_cycle();
        end
        use_fb = 1'b0;
    endtask

    task automatic test_aligned_redirect();
        drive(32'h10, 1'b0, 1'b1, 32'h40, 1'b0);
        exp_q.push_back(32'h40);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL aligned_redirect got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(32'h44);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL after_redirect got=%h exp=%h", pc_next, e); else n_pass++;
        n_checks++; if (misalign_trap !== 1'b0) $display("FAIL aligned_no_trap got=%b exp=0", misalign_trap); else n_pass++;
        n_checks++; if (redirect_pending !== 1'b0) $display("FAIL aligned_no_pending got=%b exp=0", redirect_pending); else n_pass++;
        next_cycle();
    endtask

    task automatic test_stall_redirect();
        logic [31:0] tgt [2];
        tgt[0] = 32'h80;
        tgt[1] = 32'h90;
        for (int i = 0; i < 2; i++) begin
            drive(32'h20, 1'b1, 1'b1, tgt[i], 1'b0);
            exp_q.push_back(32'h20);
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++; if (pc_next !== e) $display("FAIL stall_hold_%0d got=%h exp=%h", i, pc_next, e); else n_pass++;
            next_cycle();
            n_checks++; if (redirect_pending !== 1'b1) $display("FAIL stall_pending_%0d got=%b exp=1", i, redirect_pending); else n_pass++;
        end
        drive(32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(32'h90);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL stall_release got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (redirect_pending !== 1'b0) $display("FAIL pending_cleared got=%b exp=0", redirect_pending); else n_pass++;
        drive(32'h90, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(32'h94);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL post_release_seq got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
    endtask

    task automatic test_misalign_trap();
        drive(32'h30, 1'b0, 1'b1, 32'h42, 1'b0);
        exp_q.push_back(32'h100);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL trap_vector got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (misalign_trap !== 1'b1) $display("FAIL trap_flag got=%b exp=1", misalign_trap); else n_pass++;
        n_checks++; if (trap_pc !== 32'h42) $display("FAIL trap_pc got=%h exp=42", trap_pc); else n_pass++;
        n_checks++; if (double_fault !== 1'b0) $display("FAIL trap_no_double got=%b exp=0", double_fault); else n_pass++;
        drive(32'h100, 1'b0, 1'b1, 32'h51, 1'b0);
        exp_q.push_back(32'h104);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL double_ignored got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (double_fault !== 1'b1) $display("FAIL double_flag got=%b exp=1", double_fault); else n_pass++;
        n_checks++; if (trap_pc !== 32'h42) $display("FAIL double_trap_pc got=%h exp=42", trap_pc); else n_pass++;
        drive(32'h104, 1'b0, 1'b1, 32'h200, 1'b0);
        exp_q.push_back(32'h200);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL trap_aligned got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (misalign_trap !== 1'b1) $display("FAIL trap_sticky got=%b exp=1", misalign_trap); else n_pass++;
    endtask

    task automatic test_trap_clear();
        drive(32'h200, 1'b0, 1'b1, 32'h63, 1'b1);
        exp_q.push_back(32'h100);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL collide_pc got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (misalign_trap !== 1'b1) $display("FAIL collide_flag got=%b exp=1", misalign_trap); else n_pass++;
        n_checks++; if (trap_pc !== 32'h63) $display("FAIL collide_trap_pc got=%h exp=63", trap_pc); else n_pass++;
        n_checks++; if (double_fault !== 1'b0) $display("FAIL collide_double got=%b exp=0", double_fault); else n_pass++;
        drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        exp_q.push_back(32'h104);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL clear_pc got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (misalign_trap !== 1'b0) $display("FAIL clear_flag got=%b exp=0", misalign_trap); else n_pass++;
        n_checks++; if (double_fault !== 1'b0) $display("FAIL clear_double got=%b exp=0", double_fault); else n_pass++;
        // Back in RUN a misaligned redirect traps again instead of double-faulting.
        drive(32'h104, 1'b0, 1'b1, 32'h71, 1'b0);
        exp_q.push_back(32'h100);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL retrap_pc got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (double_fault !== 1'b0) $display("FAIL retrap_double got=%b exp=0", double_fault); else n_pass++;
        n_checks++; if (trap_pc !== 32'h71) $display("FAIL retrap_trap_pc got=%h exp=71", trap_pc); else n_pass++;
        drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b1);
        next_cycle();
        // trap_clear while in RUN changes nothing.
        drive(32'h10, 1'b0, 1'b0, 32'h0, 1'b1);
        exp_q.push_back(32'h14);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL run_clear_pc got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (misalign_trap !== 1'b0) $display("FAIL run_clear_flag got=%b exp=0", misalign_trap); else n_pass++;
    endtask

    task automatic test_back_to_back();
        // Misaligned target buffered during a stall traps on release.
        drive(32'h40, 1'b1, 1'b1, 32'h66, 1'b0);
        next_cycle();
        drive(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(32'h100);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL pend_trap_pc got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        n_checks++; if (trap_pc !== 32'h66) $display("FAIL pend_trap_target got=%h exp=66", trap_pc); else n_pass++;
        n_checks++; if (redirect_pending !== 1'b0) $display("FAIL pend_trap_cleared got=%b exp=0", redirect_pending); else n_pass++;
        // Live redirect beats a buffered one on release.
        drive(32'h50, 1'b1, 1'b1, 32'hA0, 1'b1);
        next_cycle();
        drive(32'h50, 1'b0, 1'b1, 32'hC0, 1'b0);
        exp_q.push_back(32'hC0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL newest_wins got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
    endtask

    task automatic test_wrap_async_reset();
        drive(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.push_back(32'h0);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL wrap got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
        drive(32'h50, 1'b1, 1'b1, 32'hA0, 1'b0);
        next_cycle();
        n_checks++; if (redirect_pending !== 1'b1) $display("FAIL prereset_pending got=%b exp=1", redirect_pending); else n_pass++;
        #2;
        rst_n = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL async_reset_pc got=%h exp=%h", pc_next, e); else n_pass++;
        n_checks++; if (redirect_pending !== 1'b0) $display("FAIL async_reset_pending got=%b exp=0", redirect_pending); else n_pass++;
        n_checks++; if (misalign_trap !== 1'b0) $display("FAIL async_reset_flag got=%b exp=0", misalign_trap); else n_pass++;
        next_cycle();
        use_fb = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b1;
        exp_q.push_back(32'h4);
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++; if (pc_next !== e) $display("FAIL post_reset_seq got=%h exp=%h", pc_next, e); else n_pass++;
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        use_fb   = 1'b1;
        rst_n    = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        test_reset();
        test_sequential();
        test_aligned_redirect();
        test_stall_redirect();
        test_misalign_trap();
        test_trap_clear();
        test_back_to_back();
        test_wrap_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_next_gen.md
Name: pc_next_gen

Overview:
- Next-PC sequencer sitting directly upstream of the PC register.
- Consumes the current registered pc and produces pc_next each cycle, choosing between:
  - sequential increment
  - hold (stall)
  - control-flow redirect
  - misalignment trap vector
- Owns the sequential state needed for correct redirect handling:
  - a pending-redirect buffer for redirects that arrive during a stall
  - a two-state trap FSM with sticky trap status.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, pc_next driven while rst_n low; the PC register loads this out of reset.
- TRAP_VECTOR, 32'h0000_0100, target substituted for a misaligned redirect.
- PC_INC, 4, sequential increment.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  XLEN  current PC from the PC register.
- stall  input  1  hold PC this cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  XLEN  redirect destination.
- trap_clear  input  1  acknowledge trap, return FSM to RUN.
- pc_next  output  XLEN  next PC to the PC register (combinational from state and inputs).
- redirect_pending  output  1  a redirect is buffered awaiting stall release.
- misalign_trap  output  1  sticky: misaligned redirect taken.
- double_fault  output  1  sticky: misaligned redirect seen while already in TRAP.
- trap_pc  output  XLEN  offending misaligned target.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM = RUN; pend_v = 0, pend_q = 0.
  - misalign_trap = 0, double_fault = 0, trap_pc = 0.
  - pc_next = RESET_VECTOR for the whole time rst_n is low.
  - Reset mid-stall discards any pending redirect.
- Effective redirect (eff_v / eff_t):
  - If redirect_valid: eff = redirect_target. The newest redirect wins over a buffered one.
  - Else if pend_v: eff = pend_q.
  - Otherwise no redirect.
- stall = 1:
  - pc_next = pc.
  - If redirect_valid, capture the target into pend_q and set pend_v (overwrites any earlier pending value).
  - No trap evaluation while stalled.
- stall = 0, no eff_v: pc_next = pc + PC_INC, modulo 2^XLEN (32'hFFFF_FFFC -> 0).
- stall = 0, eff_v, eff_t[1:0] == 0: pc_next = eff_t; pend_v cleared the same edge.
- stall = 0, eff_v, eff_t[1:0] != 0, FSM = RUN:
  - pc_next = TRAP_VECTOR.
  - trap_pc <= eff_t; misalign_trap <= 1; FSM -> TRAP; pend_v cleared.
- stall = 0, eff_v, misaligned, FSM = TRAP:
  - Redirect ignored; pc_next = pc + PC_INC.
  - double_fault <= 1; trap_pc unchanged; pend_v cleared.
- TRAP state: sequential flow and aligned redirects behave exactly as in RUN.
- trap_clear in TRAP:
  - FSM -> RUN; misalign_trap and double_fault cleared next edge.
  - If a misaligned eff redirect is applied in the same cycle, it is treated as a RUN-state trap: FSM stays TRAP, trap_pc updated, misalign_trap = 1, double_fault = 0.
  - trap_clear in RUN: no effect.
- redirect_pending = pend_v (registered).
- Latency: pc_next responds in the same cycle to all inputs; status outputs update on the next rising edge.

Decomposition:
- Shared package: XLEN, PC_INC, RESET_VECTOR, TRAP_VECTOR, and the FSM state enum {RUN, TRAP}. The PC register and fetch stage import the same vectors.
- One natural sub-module: pc_redirect_buf (pend_v/pend_q capture, newest-wins merge producing eff_v/eff_t).
- FSM and next-PC mux remain in pc_next_gen.

Test Plan:
- Reset then sequential run: rst_n low -> pc_next = 0. Release with pc fed back through a PC register -> pc_next = 4, 8, C, 10 on successive cycles.
- Aligned redirect: pc = 0x10, redirect_valid = 1, target = 0x40 -> pc_next = 0x40. Next cycle pc_next = 0x44. No status change.
- Redirect during stall:
  - pc = 0x20, stall = 1, redirect 0x80 -> pc_next = 0x20, then redirect_pending = 1.
  - Second redirect 0x90 while stalled -> overwrites the buffer.
  - Release stall -> pc_next = 0x90, redirect_pending = 0 next edge.
- Misaligned trap: pc = 0x30, redirect 0x42 -> pc_next = 0x100, misalign_trap = 1, trap_pc = 0x42. A further redirect 0x51 -> pc_next = pc + 4, double_fault = 1.
- Trap clear collision: in TRAP, trap_clear = 1 with redirect 0x63 -> misalign_trap stays 1, trap_pc = 0x63, double_fault = 0. trap_clear alone -> both flags 0.
- Wrap and async reset: pc = 0xFFFF_FFFC -> pc_next = 0. Assert rst_n mid-stall with pending redirect -> pending cleared immediately, pc_next = RESET_VECTOR.
